// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one byte from a first-word-fall-through TX FIFO and
// shifts out start, 8 data bits (LSB first), optional parity and one or two stop bits.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = 20
) (
    input  logic                  UCLK,
    input  logic                  PRESETn,
    input  logic                  TxEn,
    input  logic                  ParEn,
    input  logic                  ParOdd,
    input  logic                  Stop2,
    input  logic [DIV_WIDTH-1:0]  BaudDiv,
    input  logic                  TxFifoEmpty,
    input  logic [DATA_WIDTH-1:0] TxLoad,
    output logic                  ReadInc,
    output logic                  TXD,
    output logic                  TxBusy,
    output logic                  TxDone
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 par_bit_q, par_bit_d;
    logic                 par_en_q, par_en_d;
    logic                 stop_left_q, stop_left_d;
    logic                 txd_q, txd_d;
    logic                 pop;
    logic                 bit_end;

    // Only the low byte of the FIFO word is transmitted.
    generate
        if (DATA_WIDTH > 8) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^TxLoad[DATA_WIDTH-1:8];
        end
    endgenerate

    assign bit_end = (cnt_q == '0);

    always_ff @(posedge UCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            par_bit_q   <= 1'b0;
            par_en_q    <= 1'b0;
            stop_left_q <= 1'b0;
            txd_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            par_bit_q   <= par_bit_d;
            par_en_q    <= par_en_d;
            stop_left_q <= stop_left_d;
            txd_q       <= txd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        par_bit_d   = par_bit_q;
        par_en_d    = par_en_q;
        stop_left_d = stop_left_q;
        txd_d       = txd_q;
        pop         = 1'b0;

        // Every bit lasts div_q+1 cycles; each state only acts on the last one.
        if (state_q != IDLE && !bit_end) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (TxEn && !TxFifoEmpty) begin
                    pop         = 1'b1;
                    shift_d     = TxLoad[7:0];
                    par_bit_d   = (^TxLoad[7:0]) ^ ParOdd;
                    par_en_d    = ParEn;
                    stop_left_d = Stop2;
                    div_d       = BaudDiv;
                    cnt_d       = BaudDiv;
                    bit_cnt_d   = '0;
                    txd_d       = 1'b0;
                    state_d     = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d     = div_q;
                    txd_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = div_q;
                    if (bit_cnt_q == 3'd7) begin
                        if (par_en_q) begin
                            txd_d   = par_bit_q;
                            state_d = PARITY;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = div_q;
                    txd_d   = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    if (stop_left_q) begin
                        stop_left_d = 1'b0;
                        cnt_d       = div_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // Gated by reset so the FIFO never sees a pop while the block is held in reset.
    assign ReadInc = pop && PRESETn;
    assign TXD     = txd_q;
    assign TxBusy  = (state_q != IDLE);
    assign TxDone  = (state_q == STOP) && bit_end && !stop_left_q;

    a_pop_nonempty: assert property (@(posedge UCLK) disable iff (!PRESETn)
        ReadInc |-> !TxFifoEmpty);
    a_done_to_idle: assert property (@(posedge UCLK) disable iff (!PRESETn)
        TxDone |=> (state_q == IDLE));

endmodule
